// File: rtl/matriz_pkg.sv
// Shared constants, state encoding and helpers for the LED matrix scan arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matriz_pkg;

  localparam int NCOLS   = 5;
  localparam int NROWS   = 7;
  localparam int FRAME_W = NCOLS * NROWS;

  // Largest request vector the lowest_set helper can search.
  localparam int LS_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Index of the lowest bit set in vec that is not excluded by mask; 0 when none.
  function automatic logic [4:0] lowest_set(input logic [LS_W-1:0] vec,
                                            input logic [LS_W-1:0] mask);
    logic [4:0] idx;
    idx = '0;
    for (int i = LS_W - 1; i >= 0; i--) begin
      if (vec[i] && !mask[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Column scan timebase: prescaler plus column index for the 5-column matrix.
// Latency: column 0 active on the first clock after reset release; one column per SCAN_DIV clocks.
// Backpressure: none, free-running once out of reset.
module scan_timer
  import matriz_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       tick,
  output logic [2:0] col_idx,
  output logic       frame_wrap,
  output logic       active
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [2:0]       COL_LAST = 3'(NCOLS - 1);

  logic [PRE_W-1:0] prescaler;

  assign tick = active && (prescaler == PRE_LAST);
  // High throughout the last column; qualified by tick it marks the frame boundary.
  assign frame_wrap = (col_idx == COL_LAST);

  // Prescaler and column counter; the first edge out of reset only arms the scan at column 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prescaler <= '0;
      col_idx   <= '0;
      active    <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
    end else if (tick) begin
      prescaler <= '0;
      // Out-of-range column values (5..7) also fold back to column 0 here.
      col_idx   <= (col_idx >= COL_LAST) ? 3'd0 : col_idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan_arbiter.sv
// Shares the 5x7 status LED matrix between NREQ requesters: priority preemption, dwell, tear-free frame swaps.
// Latency: a request takes effect at the next frame boundary (at most 5*SCAN_DIV clocks).
// Backpressure: req is a level held by the requester; ack pulses when its frame is latched.
module matrix_scan_arbiter
  import matriz_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int DWELL_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FRAME_W-1:0] frame_in,
  output logic [NCOLS-1:0]        col_out,
  output logic [NROWS-1:0]        row_out,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    frame_start
);

  localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW_W  = $clog2(DWELL_FRAMES) + 1;
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_FRAMES - 1);

  logic       tick;
  logic [2:0] col_idx;
  logic       frame_wrap;
  logic       active;
  logic       boundary;

  arb_state_t         state, state_nxt;
  logic [OWN_W-1:0]   owner, owner_nxt;
  logic [DW_W-1:0]    dwell, dwell_nxt;
  logic [FRAME_W-1:0] fbuf, fbuf_nxt;
  logic [NREQ-1:0]    ack_nxt;
  logic [NREQ-1:0]    own_oh;
  logic               owner_req;
  logic [4:0]         any_idx;
  logic [4:0]         other_idx;
  logic               do_grant;
  logic               load_frame;
  logic [OWN_W-1:0]   target;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .col_idx    (col_idx),
    .frame_wrap (frame_wrap),
    .active     (active)
  );

  assign boundary = tick && frame_wrap;

  // Owner as a one-hot vector, plus the candidate requesters seen at a boundary.
  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      own_oh[i] = (owner == OWN_W'(i));
    end
    owner_req = |(req & own_oh);
    any_idx   = lowest_set(LS_W'(req), '0);
    other_idx = lowest_set(LS_W'(req), LS_W'(own_oh));
  end

  // Arbitration: decide the owner, dwell and frame buffer contents at each frame boundary.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    dwell_nxt  = dwell;
    fbuf_nxt   = fbuf;
    ack_nxt    = '0;
    do_grant   = 1'b0;
    load_frame = 1'b0;
    target     = owner;
    if (boundary) begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            do_grant = 1'b1;
            target   = OWN_W'(any_idx);
          end
        end
        HOLD: begin
          if (!owner_req) begin
            if (|req) begin
              do_grant = 1'b1;
              target   = OWN_W'(any_idx);
            end else begin
              state_nxt = IDLE;
              dwell_nxt = '0;
              fbuf_nxt  = '0;
            end
          end else if (any_idx < 5'(owner)) begin
            do_grant = 1'b1;
            target   = OWN_W'(any_idx);
          end else if ((dwell == DW_MAX) && |(req & ~own_oh)) begin
            do_grant = 1'b1;
            target   = OWN_W'(other_idx);
          end else begin
            // Live refresh of the current owner's picture; no ack.
            load_frame = 1'b1;
            if (dwell != DW_MAX) dwell_nxt = dwell + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (do_grant) begin
      load_frame = 1'b1;
      state_nxt  = HOLD;
      owner_nxt  = target;
      dwell_nxt  = '0;
      for (int i = 0; i < NREQ; i++) begin
        ack_nxt[i] = (target == OWN_W'(i));
      end
    end
    if (load_frame) begin
      for (int i = 0; i < NREQ; i++) begin
        if (target == OWN_W'(i)) fbuf_nxt = frame_in[i*FRAME_W +: FRAME_W];
      end
    end
  end

  // Arbitration state, frame buffer and output pulses; reset aborts any frame or dwell in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      owner       <= '0;
      dwell       <= '0;
      fbuf        <= '0;
      ack         <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      dwell       <= dwell_nxt;
      fbuf        <= fbuf_nxt;
      ack         <= ack_nxt;
      frame_start <= !active || boundary;
    end
  end

  assign grant = (state == HOLD) ? own_oh : '0;

  // Column drive and row data follow the registered column index and frame buffer.
  always_comb begin
    col_out = '0;
    row_out = '0;
    for (int c = 0; c < NCOLS; c++) begin
      col_out[c] = active && (col_idx == 3'(c));
      if ((state == HOLD) && (col_idx == 3'(c))) row_out = fbuf[c*NROWS +: NROWS];
    end
  end

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// Self-checking bench for matrix_scan_arbiter with NREQ=3, SCAN_DIV=4, DWELL_FRAMES=2.
// Reference model tracks time since reset release and applies the arbitration rules per boundary.
// Directed scenarios first, then a randomized phase with occasional resets.
module tb_matrix_scan_arbiter;

  localparam int NREQ = 3;
  localparam int SD   = 4;
  localparam int DW   = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic [2:0]   req;
  logic [104:0] frame_in;
  logic [4:0]   col_out;
  logic [6:0]   row_out;
  logic [2:0]   grant;
  logic [2:0]   ack;
  logic         frame_start;

  always #5 clk = ~clk;

  matrix_scan_arbiter #(
    .NREQ         (NREQ),
    .SCAN_DIV     (SD),
    .DWELL_FRAMES (DW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .frame_in    (frame_in),
    .col_out     (col_out),
    .row_out     (row_out),
    .grant       (grant),
    .ack         (ack),
    .frame_start (frame_start)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         started = 0;
  int         t = 0;
  int         owner = -1;
  int         dwell = 0;
  logic [6:0] mbuf [5];
  logic [4:0] e_col;
  logic [6:0] e_row;
  logic [2:0] e_grant;
  logic [2:0] e_ack;
  logic       e_fs;

  function automatic int pick(input logic [2:0] r, input int skip);
    for (int i = 0; i < 3; i++) if (r[i] && i != skip) return i;
    return -1;
  endfunction

  task automatic latch_frame(input int i);
    for (int c = 0; c < 5; c++) mbuf[c] = frame_in[i*35 + c*7 +: 7];
  endtask

  task automatic grant_to(input int i);
    owner = i;
    dwell = 0;
    latch_frame(i);
    e_ack = 3'(1 << i);
  endtask

  task automatic arbitrate();
    int lo;
    int other;
    lo    = pick(req, -1);
    other = (owner >= 0) ? pick(req, owner) : -1;
    if (owner < 0) begin
      if (lo >= 0) grant_to(lo);
    end else if (!req[owner]) begin
      if (lo >= 0) grant_to(lo);
      else begin
        owner = -1;
        for (int c = 0; c < 5; c++) mbuf[c] = '0;
      end
    end else if (lo < owner) begin
      grant_to(lo);
    end else if (dwell >= DW - 1 && other >= 0) begin
      grant_to(other);
    end else begin
      latch_frame(owner);
      if (dwell < DW - 1) dwell++;
    end
  endtask

  // Predict the outputs after the coming clock edge from the inputs currently applied.
  task automatic model_edge();
    int col;
    e_ack = '0;
    if (!rstn) begin
      started = 0;
      t       = 0;
      owner   = -1;
      dwell   = 0;
      for (int c = 0; c < 5; c++) mbuf[c] = '0;
      e_col   = '0;
      e_row   = '0;
      e_grant = '0;
      e_fs    = 1'b0;
    end else begin
      if (!started) begin
        started = 1;
        t = 0;
      end else begin
        t++;
      end
      if (t > 0 && (t % (5*SD)) == 0) arbitrate();
      col     = (t / SD) % 5;
      e_col   = 5'(1 << col);
      e_fs    = ((t % (5*SD)) == 0);
      e_grant = (owner < 0) ? 3'b000 : 3'(1 << owner);
      e_row   = (owner < 0) ? 7'h00 : mbuf[col];
    end
  endtask

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("col_out", 7'(col_out), 7'(e_col));
    check("row_out", row_out, e_row);
    check("grant", 7'(grant), 7'(e_grant));
    check("ack", 7'(ack), 7'(e_ack));
    check("frame_start", 7'(frame_start), 7'(e_fs));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [6:0]  pat [5];
    logic [63:0] rv;
    int          k;
    int          idx;

    pat[0] = 7'h7F; pat[1] = 7'h01; pat[2] = 7'h02; pat[3] = 7'h04; pat[4] = 7'h08;
    for (int c = 0; c < 5; c++) mbuf[c] = '0;

    // Reset state
    rstn = 1'b0;
    req  = 3'b000;
    rv   = {$urandom(), $urandom()};
    frame_in = '0;
    frame_in[34:0] = rv[34:0];
    rv   = {$urandom(), $urandom()};
    frame_in[104:70] = rv[34:0];
    run(3);

    // Free scan, nothing requested
    rstn = 1'b1;
    run(45);

    // Grant and latch for requester 1
    for (int c = 0; c < 5; c++) frame_in[35 + c*7 +: 7] = pat[c];
    req = 3'b010;
    k = 0;
    while (k < 40 && ack !== 3'b010) begin
      step();
      k++;
    end
    n_vec++;
    assert (ack === 3'b010) else begin
      n_err++;
      $error("FAIL ack_wait: observed ack %b expected 010", ack);
    end
    check("grant_latch_row0", row_out, pat[0]);
    for (int c = 1; c < 5; c++) begin
      run(SD);
      check("grant_latch_row", row_out, pat[c]);
    end
    run(10);

    // Owner 1 drops, requester 2 takes over, then requester 0 preempts at dwell 0
    req = 3'b100;
    run(22);
    req = 3'b101;
    run(25);

    // Hand back to requester 1, then dwell rotation towards requester 2
    req = 3'b010;
    run(20);
    req = 3'b110;
    run(80);

    // Release mid-frame with nothing else pending
    req = 3'b000;
    run(30);

    // Reset during column 2 of an owned frame
    req = 3'b001;
    k = 0;
    while (k < 200 && !(grant !== 3'b000 && col_out === 5'b00100)) begin
      step();
      k++;
    end
    n_vec++;
    assert (grant !== 3'b000 && col_out === 5'b00100) else begin
      n_err++;
      $error("FAIL col2_wait: observed grant %b col %b expected owned column 2", grant, col_out);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    run(45);

    // Randomized requests, frames, short pulses and occasional resets
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 29) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        idx = int'($urandom_range(0, 2));
        rv  = {$urandom(), $urandom()};
        frame_in[idx*35 +: 35] = rv[34:0];
      end
      rstn = ($urandom_range(0, 399) != 0);
      step();
    end
    rstn = 1'b1;
    run(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_scan_arbiter.md
Name: matrix_scan_arbiter

Overview:
- Sequences the 5-column x 7-row status LED matrix: a prescaled column scan with one-hot column drive and registered row data.
- Shares the display between NREQ requesters (e.g. alarm, valve status, idle pattern) with fixed-priority preemption and a minimum dwell time.
- Swaps frames only at frame boundaries, so there is no tearing.
- Replaces the free-running ripple column counter at the display top level.

Parameters:
- NREQ, 3: number of requesters; index 0 is the highest priority.
- SCAN_DIV, 1000: clk cycles per column (minimum 2).
- DWELL_FRAMES, 50: full frames the owner keeps the display before lower/equal-priority requesters can take it (minimum 1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- req  in  NREQ  request level per requester; held while it wants the display.
- frame_in  in  NREQ*35  per-requester frame; bit i*35 + c*7 + r is row r of column c.
- col_out  out  5  one-hot column drive, active-high.
- row_out  out  7  row data for the active column, active-high.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- ack  out  NREQ  one-cycle pulse when requester i's frame is latched.
- frame_start  out  1  one-cycle pulse when column 0 becomes active.

Behaviour:
- Reset: while rstn=0 at an edge, all outputs are 0, state=IDLE, and all counters and the frame buffer are 0. Reset asserted mid-frame or mid-dwell aborts immediately; no ack is issued.
- First edge with rstn=1: col_out=00001, row_out=0, frame_start=1, prescaler=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler==SCAN_DIV-1).
- On tick: col_idx advances 0→1→2→3→4→0. col_out and row_out update on the same edge. row_out = buf[col_idx] when owned, 0 in IDLE.
- Frame boundary = tick with col_idx==4. On that edge, col_idx wraps to 0, frame_start pulses, and arbitration runs. grant, buf and ack are all updated on the same edge.
- IDLE state:
  - Any req → grant the lowest-index requester, latch its frame, dwell=0, pulse its ack, go to HOLD.
  - No req → stay in IDLE with a blank display.
- HOLD state, evaluated only at boundaries, first match wins:
  1. Owner req=0 → release. If other requests are pending, grant the lowest-index one (latch, ack, dwell=0). Otherwise go to IDLE and clear buf.
  2. A lower-index req is pending → preempt regardless of dwell (latch, ack, dwell=0).
  3. dwell==DWELL_FRAMES-1 and another req is pending → switch to the lowest-index requester other than the owner (latch, ack, dwell=0).
  4. Otherwise → re-latch the owner's frame_in (live refresh, no ack). dwell increments and saturates at DWELL_FRAMES-1.
- req changes between boundaries have no effect until the next boundary. A req pulse shorter than one frame that misses a boundary is ignored.
- frame_in is sampled only at the boundary edge.
- Width rules:
  - prescaler width = clog2(SCAN_DIV).
  - dwell width = clog2(DWELL_FRAMES)+1.
  - col_idx is 3 bits; values 5..7 are unreachable. If they occur, force col_idx to 0 on the next tick.
- Latency: a request becomes visible at most 5*SCAN_DIV cycles after assertion, i.e. at the next boundary.

Decomposition:
- Package matriz_pkg holds:
  - NCOLS=5, NROWS=7, FRAME_W=35.
  - State encoding IDLE/HOLD.
  - A function returning the lowest set index of a vector, with an optional index mask.
- Sub-module scan_timer holds the prescaler and col_idx. Outputs: tick, col_idx, frame_wrap; it is reset by rstn.
- Arbitration and the frame buffer stay in the top level.

Test Plan:
(Parameters for all scenarios: NREQ=3, SCAN_DIV=4, DWELL_FRAMES=2.)
- Scan/reset: release rstn, no req → col_out steps 00001,00010,00100,01000,10000 every 4 cycles and repeats. row_out=0 throughout. frame_start pulses every 20 cycles. grant=000.
- Grant/latch: req=010 with frame_in[1] columns 7'h7F, 7'h01, 7'h02, 7'h04, 7'h08 → at the next boundary grant=010 and ack=010 pulses for 1 cycle. Next frame: row_out=7F,01,02,04,08 in step with col_out.
- Preempt: owner=2 in dwell 0, then req=101 → next boundary grant=001, ack=001, frame 0 shown.
- Dwell rotation: owner 1 held, req=110 → owner 1 keeps 2 frames, then at the following boundary grant=100.
- Release: owner drops req mid-frame with no other req → the current frame completes, then at the boundary grant=000 and row_out=0.
- Reset mid-operation: rstn=0 for 1 cycle during column 2 of owned frame → next edge all outputs 0. After release: col_out=00001, grant=000, no ack. The requester is re-granted at the next boundary.
